ibus_rsp_model: RTL and testbench
=================================

IBUS_RSP_MODEL -- requirements
Module: ibus_rsp_model

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the maximum number of outstanding fetch commands (power of two, 2..16).
REQ-002 The block SHALL have parameter MIN_LAT, default 1, meaning the minimum cycles from command acceptance to response (1..7).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port cmd_valid  input  1  the core requests a fetch.
REQ-006 The block SHALL have port cmd_pc  input  32  the fetch address.
REQ-007 The block SHALL have port cmd_ready  output  1  the command is accepted this cycle.
REQ-008 The block SHALL have port cmd_ready_en  input  1  free-running stall enable for command acceptance (solver/random driven).
REQ-009 The block SHALL have port rsp_valid_en  input  1  free-running stall enable for responses.
REQ-010 The block SHALL have port rsp_inst_in  input  32  unconstrained instruction data.
REQ-011 The block SHALL have port imem_addr  input  32  the halfword address tracked by the checker.
REQ-012 The block SHALL have port imem_data  input  16  the halfword value bound to imem_addr.
REQ-013 The block SHALL have port rsp_valid  output  1  the response is delivered (no back-pressure).
REQ-014 The block SHALL have port rsp_inst  output  32  the response instruction word.
REQ-015 The block SHALL have port rsp_addr  output  32  the fetch address of the head entry.
REQ-016 The block SHALL have port occupancy  output  clog2(DEPTH+1)  the count of outstanding commands.
REQ-017 The block SHALL have port misalign_err  output  1  sticky flag: an accepted cmd_pc had bit 0 set.

Function
REQ-018 cmd_ready SHALL equal cmd_ready_en AND (occupancy < DEPTH); it SHALL NOT depend on a same-cycle pop.
REQ-019 A push SHALL occur when cmd_valid AND cmd_ready: cmd_pc is written at the write pointer with age 0, and the write pointer advances modulo DEPTH.
REQ-020 Each occupied entry's age SHALL increment by 1 per cycle, saturating at MIN_LAT.
REQ-021 rsp_valid SHALL equal rsp_valid_en AND (occupancy > 0) AND (head age == MIN_LAT); therefore the earliest response comes MIN_LAT cycles after acceptance.
REQ-022 A pop SHALL occur on every cycle rsp_valid is 1, and the read pointer SHALL advance modulo DEPTH; responses SHALL be delivered in strict acceptance order.
REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged; push only SHALL add 1; pop only SHALL subtract 1.
REQ-024 When occupancy is 0, rsp_valid SHALL be 0 regardless of rsp_valid_en; a push into an empty queue SHALL NOT bypass to the response in the same cycle.
REQ-025 rsp_addr SHALL equal the head entry address whenever occupancy > 0, and 0 otherwise.
REQ-026 rsp_inst[15:0] SHALL equal imem_data if rsp_addr == imem_addr, and rsp_inst_in[15:0] otherwise.
REQ-027 rsp_inst[31:16] SHALL equal imem_data if rsp_addr+2 == imem_addr (32-bit modulo), and rsp_inst_in[31:16] otherwise.
REQ-028 misalign_err SHALL set on a push with cmd_pc[0]==1 and SHALL hold until reset.

Reset
REQ-029 While reset is high: both pointers, occupancy, all ages and all stored addresses SHALL be 0; cmd_ready, rsp_valid and misalign_err SHALL be 0.
REQ-030 A reset asserted mid-operation SHALL discard all outstanding entries; no response for a pre-reset command SHALL appear afterwards.

Structure
REQ-031 The package ibus_model_pkg SHALL hold the DEPTH/MIN_LAT defaults, the pointer-width constant and the entry typedef {addr[31:0], age}.
REQ-032 The queue SHALL be a sub-module ibus_addr_fifo that provides push/pop, pointers, per-entry age, and head and count outputs; ibus_rsp_model adds the handshake gating, data override and error flag.

Verification
REQ-033 Single fetch: MIN_LAT=1, enables=1, push pc=0x100 at cycle 0 -> rsp_valid=1 at cycle 1 with rsp_addr=0x100 and occupancy back to 0 at cycle 2.
REQ-034 Full: rsp_valid_en=0, 9 back-to-back cmd_valid -> 8 accepted (0x0..0x1C); cmd_ready=0 on the 9th; occupancy=8.
REQ-035 Simultaneous: occupancy=8, rsp_valid_en=1 -> pop with cmd_ready still 0 that cycle; next cycle cmd_ready=1 and a push/pop pair keeps occupancy=7.
REQ-036 Override: imem_addr=0x202, imem_data=0xBEEF, head addr 0x200, rsp_inst_in=0x12345678 -> rsp_inst=0xBEEF5678; head 0x204 -> rsp_inst=0x12345678.
REQ-037 Reset mid-flight: 3 outstanding entries, reset pulsed 1 cycle -> occupancy=0 and no rsp_valid until a new push plus MIN_LAT.
REQ-038 Wrap and error: 20 push/pop pairs with MIN_LAT=3 -> addresses returned in order across pointer wrap; a push of pc=0x101 -> misalign_err=1 sticky.

Source files
------------

// File: rtl/ibus_rsp_model_pkg.sv
// ---------------------------------------------------------------------------
// ibus_model_pkg
//   Shared constants and types for the instruction-bus response model.
//   - DEFAULT_DEPTH / DEFAULT_MIN_LAT : default queue depth and response latency
//   - AGE_W                           : width of the per-entry age counter
//   - DEFAULT_PTR_W / ptrWidth()      : queue pointer width
//   - entry_t                         : one queued fetch {addr, age}
// ---------------------------------------------------------------------------
package ibus_model_pkg;

  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_MIN_LAT = 1;

  // MIN_LAT tops out at 7, so three bits always hold the elapsed-cycle count.
  localparam int AGE_W = 3;

  // A one-entry queue would still need a 1-bit pointer for the array index.
  function automatic int ptrWidth(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int DEFAULT_PTR_W = ptrWidth(DEFAULT_DEPTH);

  typedef struct packed {
    logic [31:0]      addr;
    logic [AGE_W-1:0] age;
  } entry_t;

endpackage

// File: rtl/ibus_rsp_model_if.sv
// ---------------------------------------------------------------------------
// ibus_rsp_model_if
//   Fetch command / response handshake between a core and the bus model.
//   - cmd_valid, cmd_pc  : fetch request from the core
//   - cmd_ready          : command accepted this cycle
//   - rsp_valid          : response delivered (no back-pressure)
//   - rsp_inst, rsp_addr : instruction word and its fetch address
//   Modports: master = core side, slave = bus model side.
// ---------------------------------------------------------------------------
interface ibus_rsp_model_if;

  logic        cmd_valid;
  logic [31:0] cmd_pc;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;

  modport master (
    output cmd_valid,
    output cmd_pc,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_inst,
    input  rsp_addr
  );

  modport slave (
    input  cmd_valid,
    input  cmd_pc,
    output cmd_ready,
    output rsp_valid,
    output rsp_inst,
    output rsp_addr
  );

endinterface

// File: rtl/ibus_addr_fifo.sv
// ---------------------------------------------------------------------------
// ibus_addr_fifo
//   Circular queue of outstanding fetch addresses, each with an age counter.
//   Ports:
//   - clk, reset          : clock, synchronous active-high reset
//   - push, pushAddr      : enqueue pushAddr with age 0 (caller keeps count < DEPTH)
//   - pop                 : dequeue the head (caller keeps count > 0)
//   - headAddr            : address stored at the read pointer
//   - headAge             : cycles elapsed since the head was accepted, capped at MIN_LAT
//   - count               : number of occupied entries
// ---------------------------------------------------------------------------
module ibus_addr_fifo
  import ibus_model_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int MIN_LAT = DEFAULT_MIN_LAT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [31:0]                  pushAddr,
  input  logic                         pop,
  output logic [31:0]                  headAddr,
  output logic [AGE_W-1:0]             headAge,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = ptrWidth(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // The stored age is "completed cycles after the acceptance cycle", so it
  // saturates one below MIN_LAT; headAge adds the current cycle back in.
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MIN_LAT - 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [DEPTH-1:0] occupied;

  // An entry is live when its distance from the read pointer (modulo DEPTH)
  // is below the current count; only live entries age.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and infers a latch.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = CNT_W'(PTR_W'(PTR_W'(i) - rdPtr)) < count;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      // NOTE: the address array is cleared on reset because stored addresses
      // are observable state; a plain data buffer would normally skip this.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occupied[i] && (mem[i].age != AGE_MAX)) begin
          mem[i].age <= mem[i].age + AGE_W'(1);
        end
      end

      // The write slot is never live when a push is allowed, so this write
      // cannot collide with the aging update above.
      if (push) begin
        mem[wrPtr] <= entry_t'{addr: pushAddr, age: '0};
        wrPtr      <= wrPtr + PTR_W'(1);
      end

      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign headAddr = mem[rdPtr].addr;
  assign headAge  = mem[rdPtr].age + AGE_W'(1);

endmodule

// File: rtl/ibus_rsp_model.sv
// ---------------------------------------------------------------------------
// ibus_rsp_model
//   Behavioural instruction-bus responder: accepts fetch commands into an
//   in-order queue and returns each one no earlier than MIN_LAT cycles after
//   acceptance, with random stalls on both sides. Returned instruction data is
//   free (rsp_inst_in) except for one tracked halfword (imem_addr/imem_data),
//   which is substituted whenever either half of the response covers it.
//   Ports:
//   - clk, reset    : clock, synchronous active-high reset
//   - bus           : command/response handshake (slave side)
//   - cmd_ready_en  : stall enable for command acceptance
//   - rsp_valid_en  : stall enable for responses
//   - rsp_inst_in   : unconstrained instruction data
//   - imem_addr     : halfword address being tracked
//   - imem_data     : value bound to imem_addr
//   - occupancy     : number of outstanding commands
//   - misalign_err  : sticky, an accepted fetch address had bit 0 set
// ---------------------------------------------------------------------------
module ibus_rsp_model
  import ibus_model_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int MIN_LAT = DEFAULT_MIN_LAT
) (
  input  logic                         clk,
  input  logic                         reset,
  ibus_rsp_model_if.slave              bus,
  input  logic                         cmd_ready_en,
  input  logic                         rsp_valid_en,
  input  logic [31:0]                  rsp_inst_in,
  input  logic [31:0]                  imem_addr,
  input  logic [15:0]                  imem_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         misalign_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             cmdReady;
  logic             rspValid;
  logic [31:0]      headAddr;
  logic [AGE_W-1:0] headAge;
  logic [CNT_W-1:0] count;
  logic [31:0]      rspAddr;
  logic [31:0]      upperAddr;
  logic             errFlag;

  ibus_addr_fifo #(
    .DEPTH   (DEPTH),
    .MIN_LAT (MIN_LAT)
  ) addrFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushAddr (bus.cmd_pc),
    .pop      (pop),
    .headAddr (headAddr),
    .headAge  (headAge),
    .count    (count)
  );

  // Readiness looks only at the registered count: a slot freed by a pop in
  // this same cycle becomes usable on the next cycle, never combinationally.
  assign cmdReady = !reset && cmd_ready_en && (count < CNT_W'(DEPTH));
  assign push     = bus.cmd_valid && cmdReady;

  // The count test also blocks any same-cycle bypass: a push into an empty
  // queue is not visible until the following edge.
  assign rspValid = !reset && rsp_valid_en && (count != '0) &&
                    (headAge == AGE_W'(MIN_LAT));
  assign pop      = rspValid;

  assign rspAddr   = (count != '0) ? headAddr : '0;
  assign upperAddr = rspAddr + 32'd2;

  // The tracked halfword may land in either half of the 32-bit response.
  assign bus.rsp_inst[15:0]  = (rspAddr   == imem_addr) ? imem_data : rsp_inst_in[15:0];
  assign bus.rsp_inst[31:16] = (upperAddr == imem_addr) ? imem_data : rsp_inst_in[31:16];

  assign bus.cmd_ready = cmdReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_addr  = rspAddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      errFlag <= 1'b0;
    end else if (push && bus.cmd_pc[0]) begin
      errFlag <= 1'b1;
    end
  end

  // Gated so the outputs read zero throughout reset, including the first
  // cycle before any edge has cleared the registers.
  assign occupancy    = reset ? '0 : count;
  assign misalign_err = errFlag && !reset;

endmodule

// File: tb/tb_ibus_rsp_model.sv
// ---------------------------------------------------------------------------
// tb_ibus_rsp_model
//   Drives two responders (MIN_LAT=1 and MIN_LAT=3, DEPTH=8) with the same
//   stimulus and compares every output, every cycle, against a reference that
//   keeps each accepted fetch as {address, first cycle it may respond} in a
//   linear log with head/tail indices. Directed scenarios come first, then a
//   randomized stretch.
// ---------------------------------------------------------------------------
module tb_ibus_rsp_model;

  localparam int DEPTH  = 8;
  localparam int LOG_SZ = 2048;
  localparam int LAT [2] = '{1, 3};

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic [31:0] cmdPc;
  logic        cmdReadyEn;
  logic        rspValidEn;
  logic [31:0] rspInstIn;
  logic [31:0] imemAddr;
  logic [15:0] imemData;

  logic [31:0] pendInstIn   = 32'h0;
  logic [31:0] pendImemAddr = 32'hFFFF_FFF0;
  logic [15:0] pendImemData = 16'h0;

  logic [3:0]  occ0, occ1;
  logic        err0, err1;

  ibus_rsp_model_if bus0 ();
  ibus_rsp_model_if bus1 ();

  assign bus0.cmd_valid = cmdValid;
  assign bus0.cmd_pc    = cmdPc;
  assign bus1.cmd_valid = cmdValid;
  assign bus1.cmd_pc    = cmdPc;

  ibus_rsp_model #(.DEPTH(DEPTH), .MIN_LAT(1)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus0),
    .cmd_ready_en (cmdReadyEn),
    .rsp_valid_en (rspValidEn),
    .rsp_inst_in  (rspInstIn),
    .imem_addr    (imemAddr),
    .imem_data    (imemData),
    .occupancy    (occ0),
    .misalign_err (err0)
  );

  ibus_rsp_model #(.DEPTH(DEPTH), .MIN_LAT(3)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus1),
    .cmd_ready_en (cmdReadyEn),
    .rsp_valid_en (rspValidEn),
    .rsp_inst_in  (rspInstIn),
    .imem_addr    (imemAddr),
    .imem_data    (imemData),
    .occupancy    (occ1),
    .misalign_err (err1)
  );

  always #5 clk = ~clk;

  logic        gotReady [2];
  logic        gotValid [2];
  logic [31:0] gotAddr  [2];
  logic [31:0] gotInst  [2];
  logic [3:0]  gotOcc   [2];
  logic        gotErr   [2];

  assign gotReady[0] = bus0.cmd_ready;
  assign gotValid[0] = bus0.rsp_valid;
  assign gotAddr[0]  = bus0.rsp_addr;
  assign gotInst[0]  = bus0.rsp_inst;
  assign gotOcc[0]   = occ0;
  assign gotErr[0]   = err0;
  assign gotReady[1] = bus1.cmd_ready;
  assign gotValid[1] = bus1.rsp_valid;
  assign gotAddr[1]  = bus1.rsp_addr;
  assign gotInst[1]  = bus1.rsp_inst;
  assign gotOcc[1]   = occ1;
  assign gotErr[1]   = err1;

  // Reference state: accepted fetches in order, never overwritten until reset.
  logic [31:0] mAddr   [2][LOG_SZ];
  int          readyAt [2][LOG_SZ];
  int          head    [2];
  int          tail    [2];
  bit          mErr    [2];
  int          cycleNo = 0;

  logic [31:0] respLog [$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cycleNo, got, exp);
    end
  endtask

  // One clock cycle: apply inputs mid-cycle, compare both responders against
  // the reference, then advance the reference to what the next edge commits.
  task automatic step(input bit rst, input bit cv, input logic [31:0] pc,
                      input bit cre, input bit rve);
    int          size;
    bit          expReady;
    bit          expValid;
    logic [31:0] expAddr;
    logic [31:0] expInst;
    @(negedge clk);
    reset      = rst;
    cmdValid   = cv;
    cmdPc      = pc;
    cmdReadyEn = cre;
    rspValidEn = rve;
    rspInstIn  = pendInstIn;
    imemAddr   = pendImemAddr;
    imemData   = pendImemData;
    #1;
    for (int k = 0; k < 2; k++) begin
      size     = tail[k] - head[k];
      expReady = !rst && cre && (size < DEPTH);
      expValid = !rst && rve && (size > 0) && (cycleNo >= readyAt[k][head[k]]);
      expAddr  = (size > 0) ? mAddr[k][head[k]] : 32'h0;
      expInst[15:0]  = (expAddr == imemAddr) ? imemData : rspInstIn[15:0];
      expInst[31:16] = (expAddr + 32'd2 == imemAddr) ? imemData : rspInstIn[31:16];

      check($sformatf("lat%0d.cmd_ready", LAT[k]), 32'(gotReady[k]), 32'(expReady));
      check($sformatf("lat%0d.rsp_valid", LAT[k]), 32'(gotValid[k]), 32'(expValid));
      check($sformatf("lat%0d.occupancy", LAT[k]), 32'(gotOcc[k]), rst ? 32'd0 : 32'(size));
      check($sformatf("lat%0d.misalign", LAT[k]), 32'(gotErr[k]), rst ? 32'd0 : 32'(mErr[k]));
      if (!rst) begin
        check($sformatf("lat%0d.rsp_addr", LAT[k]), gotAddr[k], expAddr);
        check($sformatf("lat%0d.rsp_inst", LAT[k]), gotInst[k], expInst);
      end
      if (k == 1 && gotValid[1] === 1'b1) respLog.push_back(gotAddr[1]);

      if (rst) begin
        head[k] = 0;
        tail[k] = 0;
        mErr[k] = 1'b0;
      end else begin
        if (expValid) head[k]++;
        if (expReady && cv) begin
          mAddr[k][tail[k]]   = pc;
          readyAt[k][tail[k]] = cycleNo + LAT[k];
          tail[k]++;
          if (pc[0]) mErr[k] = 1'b1;
        end
      end
    end
    cycleNo++;
  endtask

  task automatic idle(input int n, input bit rve);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, rve);
  endtask

  initial begin
    reset      = 1'b1;
    cmdValid   = 1'b0;
    cmdPc      = 32'h0;
    cmdReadyEn = 1'b1;
    rspValidEn = 1'b1;
    rspInstIn  = 32'h0;
    imemAddr   = 32'hFFFF_FFF0;
    imemData   = 16'h0;
    for (int k = 0; k < 2; k++) begin
      head[k] = 0;
      tail[k] = 0;
      mErr[k] = 1'b0;
    end

    // Reset state.
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
    check("reset.occupancy", 32'(occ0), 32'd0);

    // Single fetch, MIN_LAT=1: respond one cycle after acceptance.
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    check("single.no_bypass", 32'(gotValid[0]), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("single.rsp_valid", 32'(gotValid[0]), 32'd1);
    check("single.rsp_addr", gotAddr[0], 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("single.occ_after", 32'(gotOcc[0]), 32'd0);
    idle(4, 1'b1);

    // Fill: nine back-to-back commands with responses stalled.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'(i * 4), 1'b1, 1'b0);
    check("full.ready_9th", 32'(gotReady[0]), 32'd0);
    check("full.occupancy", 32'(gotOcc[0]), 32'd8);

    // Pop from full: readiness only returns on the following cycle.
    step(1'b0, 1'b1, 32'h20, 1'b1, 1'b1);
    check("simul.pop_valid", 32'(gotValid[0]), 32'd1);
    check("simul.ready_low", 32'(gotReady[0]), 32'd0);
    check("simul.head0", gotAddr[0], 32'h0);
    step(1'b0, 1'b1, 32'h20, 1'b1, 1'b1);
    check("simul.ready_back", 32'(gotReady[0]), 32'd1);
    check("simul.occ_7", 32'(gotOcc[0]), 32'd7);
    check("simul.head1", gotAddr[0], 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("simul.occ_kept", 32'(gotOcc[0]), 32'd7);
    idle(14, 1'b1);

    // Tracked-halfword override in the upper half, then no override.
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h204, 1'b1, 1'b0);
    idle(3, 1'b0);
    pendImemAddr = 32'h202;
    pendImemData = 16'hBEEF;
    pendInstIn   = 32'h1234_5678;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("override.hit", gotInst[0], 32'hBEEF_5678);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("override.miss", gotInst[0], 32'h1234_5678);
    idle(4, 1'b1);

    // Reset with three entries in flight discards them.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'(32'h280 + i * 4), 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      check("rstmid.no_valid", 32'(gotValid[0]), 32'd0);
      check("rstmid.occ", 32'(gotOcc[0]), 32'd0);
    end
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    check("rstmid.push_no_bypass", 32'(gotValid[0]), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("rstmid.new_valid", 32'(gotValid[0]), 32'd1);
    check("rstmid.new_addr", gotAddr[0], 32'h300);
    idle(5, 1'b1);

    // Twenty streamed fetches through the MIN_LAT=3 queue, across pointer wrap.
    respLog.delete();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 32'(32'h400 + i * 4), 1'b1, 1'b1);
    idle(6, 1'b1);
    check("wrap.count", 32'(respLog.size()), 32'd20);
    for (int i = 0; i < respLog.size() && i < 20; i++) begin
      check($sformatf("wrap.order%0d", i), respLog[i], 32'(32'h400 + i * 4));
    end

    // Misaligned fetch sets a sticky error.
    step(1'b0, 1'b1, 32'h101, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      check("misalign.sticky0", 32'(err0), 32'd1);
      check("misalign.sticky1", 32'(err1), 32'd1);
    end

    // Randomized traffic over a small address window so overrides hit often.
    for (int n = 0; n < 700; n++) begin
      logic [31:0] pc;
      pc = 32'($urandom_range(0, 31)) * 32'd2 + (($urandom_range(0, 19) == 0) ? 32'd1 : 32'd0);
      pendInstIn   = $urandom;
      pendImemAddr = 32'($urandom_range(0, 33)) * 32'd2;
      pendImemData = 16'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, pc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
